dm_periph: RTL

Memory-mapped peripheral responder on the CPU data bus: the target end of the CPU's data-memory write/read channel, sitting alongside data_mem. It holds the timer compare and mode registers, latches timer events into interrupt flags gated by enables, and drives the interrupt request lines consumed by the interrupt block. Read data is returned with data_mem's one-cycle latency plus a hit flag, so the top level can multiplex the two read sources.

---
 rtl/periph_pkg.sv | 24 ++
 rtl/dm_periph_irq_flag.sv | 37 +++
 rtl/dm_periph.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/periph_pkg.sv
// Shared definitions for the dm_periph data-bus peripheral.
//   - register offsets inside the 16-word window
//   - default window base address
//   - timer mode encoding
package periph_pkg;

    localparam logic [11:0] DEF_BASE = 12'hF00;

    localparam logic [3:0] OFF_TACCR_A = 4'd0;
    localparam logic [3:0] OFF_TACCR_B = 4'd1;
    localparam logic [3:0] OFF_MODE    = 4'd2;
    localparam logic [3:0] OFF_IFG     = 4'd3;
    localparam logic [3:0] OFF_IE      = 4'd4;
    localparam logic [3:0] OFF_TICK    = 4'd5;
    localparam logic [3:0] OFF_SCRATCH = 4'd6;

    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_UP   = 2'd1,
        MODE_CONT = 2'd2,
        MODE_UPDN = 2'd3
    } tmr_mode_t;

endpackage

// File: rtl/dm_periph_irq_flag.sv
// One interrupt flag / enable pair.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   set         : event pulse, sets the flag (wins over clear)
//   clr         : write-1-clear strobe for the flag
//   en_we, en_d : enable bit write strobe and data
//   flag, en    : stored flag and enable bits
//   req         : flag & en, no extra register stage
module irq_flag (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    input  logic en_we,
    input  logic en_d,
    output logic flag,
    output logic en,
    output logic req
);

    always_ff @(posedge clk) begin
        if (reset) begin
            flag <= 1'b0;
            en   <= 1'b0;
        end else begin
            if (set)
                flag <= 1'b1;
            else if (clr)
                flag <= 1'b0;
            if (en_we)
                en <= en_d;
        end
    end

    assign req = flag & en;

endmodule

// File: rtl/dm_periph.sv
// Memory-mapped peripheral responder on the CPU data bus. Holds the timer
// compare/mode registers, the interrupt flags/enables and a scratch word, and
// returns read data with one cycle of latency plus a HIT flag so the top
// level can mux it against data_mem.
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   DMAW, DMO, WRV      : write address, data, strobe
//   DMAR, RDV           : read address, strobe
//   DQ, HIT             : registered read data and window-hit flag
//   TACCR_A, TACCR_B    : timer compare values
//   MODE_A, MODE_B      : timer modes
//   IRT_A, IRT_B        : timer event pulses
//   IRQ                 : bit1 = timer A request, bit0 = timer B request
// Build option: PERIPH_TICK_EN adds a free-running 16-bit counter at
// offset 5; without it offset 5 reads 0.
module dm_periph
    import periph_pkg::*;
#(
    parameter logic [11:0] BASE = DEF_BASE
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [11:0] DMAW,
    input  logic [15:0] DMO,
    input  logic        WRV,
    input  logic [11:0] DMAR,
    input  logic        RDV,
    output logic [15:0] DQ,
    output logic        HIT,
    output logic [15:0] TACCR_A,
    output logic [15:0] TACCR_B,
    output tmr_mode_t   MODE_A,
    output tmr_mode_t   MODE_B,
    input  logic        IRT_A,
    input  logic        IRT_B,
    output logic [1:0]  IRQ
);

    logic        wr_hit;
    logic        rd_hit;
    logic [3:0]  wr_off;
    logic [3:0]  rd_off;
    logic [15:0] scratch;
    logic [15:0] tick;
    logic [15:0] rdata;
    logic        ifg_a, ifg_b, ie_a, ie_b;
    logic        we_ifg, we_ie;

    assign wr_hit = WRV && (DMAW[11:4] == BASE[11:4]);
    assign rd_hit = DMAR[11:4] == BASE[11:4];
    assign wr_off = DMAW[3:0];
    assign rd_off = DMAR[3:0];
    assign we_ifg = wr_hit && (wr_off == OFF_IFG);
    assign we_ie  = wr_hit && (wr_off == OFF_IE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            TACCR_A <= '0;
            TACCR_B <= '0;
            MODE_A  <= MODE_STOP;
            MODE_B  <= MODE_STOP;
            scratch <= '0;
        end else if (wr_hit) begin
            case (wr_off)
                OFF_TACCR_A: TACCR_A <= DMO;
                OFF_TACCR_B: TACCR_B <= DMO;
                OFF_MODE: begin
                    MODE_A <= tmr_mode_t'(DMO[1:0]);
                    MODE_B <= tmr_mode_t'(DMO[3:2]);
                end
                OFF_SCRATCH: scratch <= DMO;
                default: ;
            endcase
        end
    end

`ifdef PERIPH_TICK_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            tick <= '0;
        else
            tick <= tick + 16'd1;
    end
`else
    assign tick = '0;
`endif

    irq_flag u_flag_a (
        .clk   (CLK),
        .reset (RESET),
        .set   (IRT_A),
        .clr   (we_ifg && DMO[0]),
        .en_we (we_ie),
        .en_d  (DMO[0]),
        .flag  (ifg_a),
        .en    (ie_a),
        .req   (IRQ[1])
    );

    irq_flag u_flag_b (
        .clk   (CLK),
        .reset (RESET),
        .set   (IRT_B),
        .clr   (we_ifg && DMO[1]),
        .en_we (we_ie),
        .en_d  (DMO[1]),
        .flag  (ifg_b),
        .en    (ie_b),
        .req   (IRQ[0])
    );

    // Read mux sees register state before this edge's updates, so a
    // same-cycle write, flag set or tick increment is not yet visible.
    always_comb begin
        rdata = '0;
        case (rd_off)
            OFF_TACCR_A: rdata = TACCR_A;
            OFF_TACCR_B: rdata = TACCR_B;
            OFF_MODE:    rdata = {12'd0, MODE_B, MODE_A};
            OFF_IFG:     rdata = {14'd0, ifg_b, ifg_a};
            OFF_IE:      rdata = {14'd0, ie_b, ie_a};
            OFF_TICK:    rdata = tick;
            OFF_SCRATCH: rdata = scratch;
            default:     rdata = '0;
        endcase
    end

    // DQ only loads on a hit read; HIT drops on any cycle without one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            DQ  <= '0;
            HIT <= 1'b0;
        end else begin
            HIT <= RDV && rd_hit;
            if (RDV && rd_hit)
                DQ <= rdata;
        end
    end

endmodule
